// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: external memory bus controller.
// Serialises one core load/store request at a time onto a multiplexed pad bus:
// an address phase (ALE high), an access phase with a programmable minimum
// number of wait states plus target-driven extension via nWait, and a one-cycle
// turnaround phase that also returns the response. An access that is still
// waiting after TIMEOUT cycles is aborted and reported with RspErr.
// All pad outputs and response outputs are registered. Their next values are
// derived from the next state, so each registered output matches the state it
// belongs to.
module mem_bus_ctrl #(
  parameter int DW       = 16,  // data / pad bus width
  parameter int AW       = 16,  // address width, AW <= DW
  parameter int MIN_WAIT = 0,   // wait states always inserted in ACCESS (0..15)
  parameter int TIMEOUT  = 15   // ACCESS cycles before abort, > MIN_WAIT
) (
  input  logic          Clock,
  input  logic          nReset,
  // core request port
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic          ReqWrite,
  input  logic [AW-1:0] ReqAddr,
  input  logic [DW-1:0] ReqWData,
  // core response port
  output logic          RspValid,
  output logic [DW-1:0] RspData,
  output logic          RspErr,
  // pad bus
  output logic [DW-1:0] DataOut,
  input  logic [DW-1:0] DataIn,
  output logic          ALE,
  output logic          nME,
  output logic          nOE,
  output logic          ENB,
  input  logic          nWait
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_ACCESS,
    S_END
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Request captured on acceptance; the core may change its port afterwards.
  logic            write_q, write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  // Registered pad and response outputs.
  logic            ale_q, ale_d;
  logic            nme_q, nme_d;
  logic            noe_q, noe_d;
  logic            enb_q, enb_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            min_met;
  logic            access_done;
  logic            access_timeout;

  // Minimum wait satisfied; with no minimum the comparison is skipped entirely.
  if (MIN_WAIT == 0) begin : g_no_min_wait
    assign min_met = 1'b1;
  end else begin : g_min_wait
    assign min_met = (cnt_q >= CW'(MIN_WAIT));
  end

  // Completion takes priority over timeout when both occur in the same cycle.
  assign access_done    = min_met && nWait;
  assign access_timeout = (cnt_q == CW'(TIMEOUT - 1));

  assign ReqReady = (state_q == S_IDLE);

  // Next-state, request latch, counter and registered-output next values.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ale_d       = 1'b0;
    nme_d       = 1'b1;
    noe_d       = 1'b1;
    enb_d       = 1'b0;
    dout_d      = dout_q;      // DataOut holds its last value while ENB=0
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;  // RspData holds until the next response
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          write_d = ReqWrite;
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          state_d = S_ADDR;
          // Address phase outputs: drive the zero-extended address.
          ale_d   = 1'b1;
          enb_d   = 1'b1;
          dout_d  = DW'(ReqAddr);
        end
      end

      S_ADDR: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
        nme_d   = 1'b0;
        if (write_q) begin
          enb_d  = 1'b1;
          dout_d = wdata_q;
        end else begin
          noe_d  = 1'b0;
        end
      end

      S_ACCESS: begin
        if (access_done) begin
          state_d     = S_END;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = write_q ? '0 : DataIn;
          rsp_err_d   = 1'b0;
        end else if (access_timeout) begin
          state_d     = S_END;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          // Stay in ACCESS with the same bus drive.
          cnt_d = cnt_q + CW'(1);
          nme_d = 1'b0;
          if (write_q) begin
            enb_d  = 1'b1;
            dout_d = wdata_q;
          end else begin
            noe_d  = 1'b0;
          end
        end
      end

      S_END: begin
        // Turnaround: bus released, response already registered.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (!nReset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ale_q       <= 1'b0;
      nme_q       <= 1'b1;
      noe_q       <= 1'b1;
      enb_q       <= 1'b0;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ale_q       <= ale_d;
      nme_q       <= nme_d;
      noe_q       <= noe_d;
      enb_q       <= enb_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign ALE      = ale_q;
  assign nME      = nme_q;
  assign nOE      = noe_q;
  assign ENB      = enb_q;
  assign DataOut  = dout_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspErr   = rsp_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl. Three instances share one stimulus bus:
//   a: DW=16 AW=16 MIN_WAIT=0, b: DW=16 AW=16 MIN_WAIT=2, c: DW=32 AW=24 MIN_WAIT=0.
// Each transaction targets one instance; only that instance's outputs are checked.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req_valid;
  logic        req_write;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] data_in;
  logic        n_wait;

  logic        a_ready, a_rsp_valid, a_rsp_err, a_ale, a_nme, a_noe, a_enb;
  logic [15:0] a_rsp_data, a_dout;
  logic        b_ready, b_rsp_valid, b_rsp_err, b_ale, b_nme, b_noe, b_enb;
  logic [15:0] b_rsp_data, b_dout;
  logic        c_ready, c_rsp_valid, c_rsp_err, c_ale, c_nme, c_noe, c_enb;
  logic [31:0] c_rsp_data, c_dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.DW(16), .AW(16), .MIN_WAIT(0), .TIMEOUT(15)) u_dut_a (
    .Clock(clk), .nReset(n_reset),
    .ReqValid(req_valid), .ReqReady(a_ready), .ReqWrite(req_write),
    .ReqAddr(req_addr[15:0]), .ReqWData(req_wdata[15:0]),
    .RspValid(a_rsp_valid), .RspData(a_rsp_data), .RspErr(a_rsp_err),
    .DataOut(a_dout), .DataIn(data_in[15:0]),
    .ALE(a_ale), .nME(a_nme), .nOE(a_noe), .ENB(a_enb), .nWait(n_wait)
  );

  mem_bus_ctrl #(.DW(16), .AW(16), .MIN_WAIT(2), .TIMEOUT(15)) u_dut_b (
    .Clock(clk), .nReset(n_reset),
    .ReqValid(req_valid), .ReqReady(b_ready), .ReqWrite(req_write),
    .ReqAddr(req_addr[15:0]), .ReqWData(req_wdata[15:0]),
    .RspValid(b_rsp_valid), .RspData(b_rsp_data), .RspErr(b_rsp_err),
    .DataOut(b_dout), .DataIn(data_in[15:0]),
    .ALE(b_ale), .nME(b_nme), .nOE(b_noe), .ENB(b_enb), .nWait(n_wait)
  );

  mem_bus_ctrl #(.DW(32), .AW(24), .MIN_WAIT(0), .TIMEOUT(15)) u_dut_c (
    .Clock(clk), .nReset(n_reset),
    .ReqValid(req_valid), .ReqReady(c_ready), .ReqWrite(req_write),
    .ReqAddr(req_addr), .ReqWData(req_wdata),
    .RspValid(c_rsp_valid), .RspData(c_rsp_data), .RspErr(c_rsp_err),
    .DataOut(c_dout), .DataIn(data_in),
    .ALE(c_ale), .nME(c_nme), .nOE(c_noe), .ENB(c_enb), .nWait(n_wait)
  );

  // View of the instance selected by sel, zero-extended to 32 bits.
  int          sel = 0;
  logic        s_ready, s_rsp_valid, s_rsp_err, s_ale, s_nme, s_noe, s_enb;
  logic [31:0] s_rsp_data, s_dout;

  always_comb begin
    s_ready = a_ready; s_rsp_valid = a_rsp_valid; s_rsp_err = a_rsp_err;
    s_ale = a_ale; s_nme = a_nme; s_noe = a_noe; s_enb = a_enb;
    s_rsp_data = 32'(a_rsp_data); s_dout = 32'(a_dout);
    if (sel == 1) begin
      s_ready = b_ready; s_rsp_valid = b_rsp_valid; s_rsp_err = b_rsp_err;
      s_ale = b_ale; s_nme = b_nme; s_noe = b_noe; s_enb = b_enb;
      s_rsp_data = 32'(b_rsp_data); s_dout = 32'(b_dout);
    end else if (sel == 2) begin
      s_ready = c_ready; s_rsp_valid = c_rsp_valid; s_rsp_err = c_rsp_err;
      s_ale = c_ale; s_nme = c_nme; s_noe = c_noe; s_enb = c_enb;
      s_rsp_data = c_rsp_data; s_dout = c_dout;
    end
  end

  typedef struct {
    int          sel;        // 0=a, 1=b, 2=c
    logic        wr;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    int          nwait_low;  // ACCESS cycles with nWait held low
    int          exp_len;    // expected ACCESS length in cycles
    logic [31:0] exp_aout;   // expected DataOut during ADDR
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) on falling edges until the selected instance is ready.
  task automatic wait_ready();
    int waited = 0;
    @(negedge clk);
    while (!s_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", 32'(s_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int len = 0;
    sel = v.sel;
    wait_ready();
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    data_in   = v.din;
    n_wait    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    // ADDR cycle
    check("addr_ale", 32'(s_ale), 32'd1);
    check("addr_nme", 32'(s_nme), 32'd1);
    check("addr_enb", 32'(s_enb), 32'd1);
    check("addr_dout", s_dout, v.exp_aout);
    @(negedge clk);
    // ACCESS cycles
    while (s_nme == 1'b0 && len < 40) begin
      check("acc_ale", 32'(s_ale), 32'd0);
      check("acc_noe", 32'(s_noe), 32'(v.wr));
      check("acc_enb", 32'(s_enb), 32'(v.wr));
      if (v.wr) check("acc_wdata", s_dout, v.wdata);
      n_wait = (len >= v.nwait_low);
      len++;
      @(negedge clk);
    end
    n_wait = 1'b1;
    // END cycle
    check("acc_len", 32'(len), 32'(v.exp_len));
    check("end_rsp_valid", 32'(s_rsp_valid), 32'd1);
    check("end_rsp_data", s_rsp_data, v.exp_data);
    check("end_rsp_err", 32'(s_rsp_err), 32'(v.exp_err));
    check("end_bus_idle", {28'd0, s_ale, s_nme, s_noe, s_enb}, 32'b0110);
    @(negedge clk);
    check("post_rsp_valid", 32'(s_rsp_valid), 32'd0);
    check("post_rsp_hold", s_rsp_data, v.exp_data);
    check("post_ready", 32'(s_ready), 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    int acc_cyc[3];
    logic [23:0] b2b_addr[3];
    logic [31:0] b2b_exp[3];
    int k;
    int cyc;
    int pulses;

    vecs[0] = '{0, 1'b0, 24'h001234, 32'h0,    32'h0000BEEF, 0,  1,  32'h00001234, 32'h0000BEEF, 1'b0};
    vecs[1] = '{0, 1'b1, 24'h000042, 32'h1357, 32'h0000FFFF, 0,  1,  32'h00000042, 32'h00000000, 1'b0};
    vecs[2] = '{0, 1'b0, 24'h0000FF, 32'h0,    32'h0000CAFE, 5,  6,  32'h000000FF, 32'h0000CAFE, 1'b0};
    vecs[3] = '{0, 1'b0, 24'h000001, 32'h0,    32'h00005555, 99, 15, 32'h00000001, 32'h00000000, 1'b1};
    vecs[4] = '{0, 1'b0, 24'h008000, 32'h0,    32'h00007E57, 14, 15, 32'h00008000, 32'h00007E57, 1'b0};
    vecs[5] = '{1, 1'b1, 24'h000010, 32'hA5A5, 32'h00001234, 0,  3,  32'h00000010, 32'h00000000, 1'b0};
    vecs[6] = '{1, 1'b0, 24'h000020, 32'h0,    32'h00001111, 1,  3,  32'h00000020, 32'h00001111, 1'b0};
    vecs[7] = '{1, 1'b0, 24'h000030, 32'h0,    32'h00002222, 4,  5,  32'h00000030, 32'h00002222, 1'b0};
    vecs[8] = '{2, 1'b0, 24'hABCDEF, 32'h0,    32'hDEADBEEF, 0,  1,  32'h00ABCDEF, 32'hDEADBEEF, 1'b0};
    vecs[9] = '{0, 1'b1, 24'h000099, 32'h4321, 32'h00000000, 99, 15, 32'h00000099, 32'h00000000, 1'b1};

    n_reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; data_in = '0; n_wait = 1'b1;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;

    // Reset state of instance a
    sel = 0;
    check("rst_ale", 32'(s_ale), 32'd0);
    check("rst_nme", 32'(s_nme), 32'd1);
    check("rst_noe", 32'(s_noe), 32'd1);
    check("rst_enb", 32'(s_enb), 32'd0);
    check("rst_dout", s_dout, 32'd0);
    check("rst_rsp_valid", 32'(s_rsp_valid), 32'd0);
    check("rst_rsp_data", s_rsp_data, 32'd0);
    check("rst_rsp_err", 32'(s_rsp_err), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Back-to-back reads on instance c with ReqValid held high
    sel = 2;
    b2b_addr[0] = 24'h123456; b2b_exp[0] = 32'h00123456;
    b2b_addr[1] = 24'hABCDEF; b2b_exp[1] = 32'h00ABCDEF;
    b2b_addr[2] = 24'hFF0001; b2b_exp[2] = 32'h00FF0001;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = b2b_addr[0];
    data_in = 32'h600DF00D; n_wait = 1'b1;
    k = 0; cyc = 0; pulses = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc++;
      if (c_ale && k < 3) begin
        check("b2b_dout", c_dout, b2b_exp[k]);
        acc_cyc[k] = cyc;
        k++;
        if (k == 3) req_valid = 1'b0;
        else        req_addr  = b2b_addr[k];
      end
      if (c_rsp_valid) pulses++;
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(k), 32'd3);
    check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    check("b2b_pulses", 32'(pulses), 32'd3);

    // Reset asserted in the middle of an ACCESS on instance a
    sel = 0;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000777; n_wait = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_in_access", 32'(s_nme), 32'd0);
    n_reset = 1'b0;
    @(negedge clk);
    check("mid_rst_bus", {28'd0, s_ale, s_nme, s_noe, s_enb}, 32'b0110);
    check("mid_rst_rsp", 32'(s_rsp_valid), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    n_wait  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_rsp_valid) pulses++;
    end
    check("mid_no_rsp", 32'(pulses), 32'd0);
    check("mid_ready", 32'(s_ready), 32'd1);
    check("mid_nme", 32'(s_nme), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
